i2s_tx_sample_fifo: RTL

Stereo playback buffer directly upstream of the I2S controller's transmit path. It accepts processed left/right sample pairs from the spatial-audio DSP chain over a valid/ready handshake and stores them in a FIFO. It presents one pair on `l_data_tx`/`r_data_tx` per frame, advancing on the controller's `new_sample_pulse`. It primes before playback, mutes on underrun, and counts underrun events.

---
 rtl/i2s_tx_sample_fifo.sv | 115 +++++++++++
 1 files changed

// File: rtl/i2s_tx_sample_fifo.sv
// Stereo sample FIFO feeding the I2S transmit path: primes, plays one pair per
// frame tick, mutes and counts on underrun.
module i2s_tx_sample_fifo #(
   parameter int unsigned DATA_W  = 24,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned PREFILL = 4
) (
   input  logic                       clk_audio,
   input  logic                       reset_n,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [DATA_W-1:0]          s_l_data,
   input  logic [DATA_W-1:0]          s_r_data,
   input  logic                       sample_tick,
   input  logic                       flush,
   output logic [DATA_W-1:0]          l_data_tx,
   output logic [DATA_W-1:0]          r_data_tx,
   output logic                       playing,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic [15:0]                underrun_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned PW = 2 * DATA_W;

   localparam logic [0:0] ST_PRIME = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]    state;
   logic [0:0]    state_nxt;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [PW-1:0] mem [DEPTH];
   logic [PW-1:0] rd_pair;
   logic          push;
   logic          pop;
   logic          underrun;
   logic          empty;

   assign empty   = (fill_level == '0);
   assign s_ready = (fill_level != CW'(DEPTH));
   assign push    = s_valid && s_ready && !flush;
   assign rd_pair = mem[rd_ptr];
   assign playing = (state == ST_RUN);

   always_ff @(posedge clk_audio or negedge reset_n) begin
      if (!reset_n) state <= ST_PRIME;
      else          state <= state_nxt;
   end

   // Tick handling: the empty check uses the pre-push occupancy.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      underrun  = 1'b0;
      if (flush) begin
         state_nxt = ST_PRIME;
      end else if (sample_tick) begin
         case (state)
            ST_PRIME: begin
               if (fill_level >= CW'(PREFILL)) begin
                  pop       = 1'b1;
                  state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (empty) begin
                  underrun  = 1'b1;
                  state_nxt = ST_PRIME;
               end else begin
                  pop = 1'b1;
               end
            end
            default: state_nxt = ST_PRIME;
         endcase
      end
   end

   // Sample storage carries no reset; contents are qualified by fill_level.
   always_ff @(posedge clk_audio) begin
      if (push) mem[wr_ptr] <= {s_l_data, s_r_data};
   end

   always_ff @(posedge clk_audio or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fill_level   <= '0;
         l_data_tx    <= '0;
         r_data_tx    <= '0;
         underrun_cnt <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         l_data_tx  <= '0;
         r_data_tx  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         fill_level <= fill_level + CW'(push) - CW'(pop);
         if (pop) begin
            l_data_tx <= rd_pair[PW-1:DATA_W];
            r_data_tx <= rd_pair[DATA_W-1:0];
         end else if (underrun) begin
            l_data_tx <= '0;
            r_data_tx <= '0;
         end
         if (underrun && (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
      end
   end

endmodule
